cam_pixel_capture: RTL and testbench
====================================

Name: cam_pixel_capture

Overview:
- Upstream stage of the pixel write counter and frame buffer. Converts the OV7670 byte stream (PCLK/VSYNC/HREF/D[7:0], RGB565, 2 bytes per pixel) into 8-bit RGB332 pixels.
- Emits one write strobe per pixel, with a linear buffer address and frame-level status.
- The write strobe is the per-pixel pulse consumed by the downstream write counter and the buffer write port.

Parameters:
- H_PIX, 160, pixels accepted per line; extra pixels in a line are dropped.
- V_LINES, 120, lines accepted per frame; extra lines are dropped.
- ADDR_W, 15, width of px_addr; must satisfy 2^ADDR_W >= H_PIX*V_LINES.

Ports:
- pclk  input  1  camera pixel clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  capture enable (camera init done); sampled only in IDLE.
- vsync  input  1  OV7670 VSYNC; high = vertical blanking.
- href  input  1  OV7670 HREF; high = valid byte on d.
- d  input  8  camera data byte.
- px_data  output  8  RGB332 pixel {R[4:2],G[5:3],B[4:3]}.
- px_wr  output  1  one-cycle write strobe for px_data/px_addr.
- px_addr  output  ADDR_W  linear buffer address of current pixel.
- frame_done  output  1  one-cycle pulse at end of captured frame.
- busy  output  1  high while in CAPTURE.
- px_ovf  output  1  sticky: pixels/lines beyond H_PIX/V_LINES seen in current frame.

Behaviour:
- Reset (rst=0, async): state=IDLE. px_data=0, px_wr=0, px_addr=0, frame_done=0, busy=0, px_ovf=0. Byte phase=0, column=0, line=0.
- vsync and href are registered once internally (prev values) for edge detection. Edges are evaluated on the registered copies. d is used in the same cycle as href=1.
- States: IDLE, WAIT_SOF, CAPTURE.
  - IDLE -> WAIT_SOF when en=1.
  - WAIT_SOF -> CAPTURE on vsync falling edge. On entry: px_addr=0, column=0, line=0, px_ovf=0, phase=0.
  - CAPTURE -> WAIT_SOF on vsync rising edge. frame_done=1 for exactly that cycle.
  - en is ignored outside IDLE. A frame in progress always completes.
- Byte pairing in CAPTURE, each cycle with href=1:
  - phase 0: latch hi={d[7:5],d[2:0]} (R[4:2],G[5:3]); phase<=1.
  - phase 1: px_data<={hi,d[4:3]}; phase<=0. px_wr=1 next cycle if column<H_PIX and line<V_LINES, else px_ovf<=1.
- Latency: second byte sampled at edge k -> px_wr, px_data, px_addr valid for the cycle after edge k. px_wr is never high two consecutive cycles (minimum 2 pclk per pixel).
- px_addr holds the address of the pixel being written while px_wr=1. It increments by 1 on the cycle after each accepted write. It never exceeds H_PIX*V_LINES-1 while px_wr is high.
- Column increments per completed pixel, accepted or dropped. Column=0 and phase=0 on href rising edge.
- href falling edge with phase=1: the orphan byte is discarded; no write occurs.
- href falling edge with column>0: line increments, saturating at V_LINES.
- Line indexing is implicit in px_addr. A short line (column<H_PIX) does not pad; the next line continues at the next address.
- vsync rising mid-pixel: partial pixel discarded, frame_done still pulses.
- rst asserted mid-frame: immediate return to IDLE with all outputs at reset values. A pending px_wr is cancelled.
- href=1 while in IDLE or WAIT_SOF: ignored; no px_wr.

Test Plan:
- Reset/idle: rst=0 then 1, en=0, toggle vsync/href with data -> px_wr stays 0, busy=0, all outputs 0.
- Single pixel: en=1, vsync 1->0, href=1 with bytes 0xF8,0x1F -> one px_wr cycle after the 2nd byte, px_data=0xE3, px_addr=0. Address becomes 1 afterwards.
- Full frame: 120 lines x 160 pixels of RGB565 0x07E0 (bytes 0x07,0xE0), then vsync rise:
  - 19200 px_wr pulses, px_data=0x1C, last px_addr=19199.
  - frame_done exactly one pulse, px_ovf=0.
- Overflow: line of 162 pixels, then 121 lines -> extra pixels/lines produce no px_wr. px_ovf=1 until the next vsync falling edge, then 0. px_addr max 19199.
- Orphan byte: href high for 3 bytes (0xFF,0xFF,0xAA) then low -> exactly one px_wr with 0xFF. The next line's first pixel pairs correctly from its own first byte.
- Reset mid-frame: rst=0 at pixel 500 -> outputs 0 immediately (async). After release with en=1 and a new frame, px_addr restarts at 0.

Source files
------------

// File: rtl/cam_pixel_capture.sv
// ---------------------------------------------------------------------------
// cam_pixel_capture: OV7670 RGB565 byte stream -> RGB332 pixel writes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cam_pixel_capture #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [7:0]        px_data,
  output logic              px_wr,
  output logic [ADDR_W-1:0] px_addr,
  output logic              frame_done,
  output logic              busy,
  output logic              px_ovf
);

  localparam int COL_W  = $clog2(H_PIX + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_PIX);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_LINES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_CAPTURE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              vsync_q, href_q;
  logic              phase_q, phase_d;
  logic [5:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [7:0]        px_data_q, px_data_d;
  logic              px_wr_q, px_wr_d;
  logic [ADDR_W-1:0] px_addr_q, px_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              px_ovf_q, px_ovf_d;

  logic              vsync_rise, vsync_fall, href_rise, href_fall;
  logic              eff_phase;
  logic [COL_W-1:0]  eff_col;

  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign href_rise  = href & ~href_q;
  assign href_fall  = ~href & href_q;

  // A new line restarts pairing and column count on the very byte that raises href.
  assign eff_phase = href_rise ? 1'b0 : phase_q;
  assign eff_col   = href_rise ? '0 : col_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (en) state_d = S_WAIT_SOF;
      S_WAIT_SOF: if (vsync_fall) state_d = S_CAPTURE;
      S_CAPTURE:  if (vsync_rise) state_d = S_WAIT_SOF;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CAPTURE);
  end

  always_comb begin
    phase_d      = phase_q;
    hi_d         = hi_q;
    col_d        = col_q;
    line_d       = line_q;
    px_data_d    = px_data_q;
    px_wr_d      = 1'b0;
    px_addr_d    = px_addr_q;
    frame_done_d = 1'b0;
    px_ovf_d     = px_ovf_q;

    if (state_q == S_WAIT_SOF && vsync_fall) begin
      phase_d   = 1'b0;
      col_d     = '0;
      line_d    = '0;
      px_addr_d = '0;
      px_ovf_d  = 1'b0;
    end

    if (state_q == S_CAPTURE) begin
      if (px_wr_q) px_addr_d = px_addr_q + 1'b1;
      if (vsync_rise) begin
        frame_done_d = 1'b1;
        phase_d      = 1'b0;
      end else if (href) begin
        if (!eff_phase) begin
          hi_d    = {d[7:5], d[2:0]};
          phase_d = 1'b1;
          col_d   = eff_col;
        end else begin
          phase_d   = 1'b0;
          px_data_d = {hi_q, d[4:3]};
          if (eff_col < COL_MAX && line_q < LINE_MAX) px_wr_d  = 1'b1;
          else                                         px_ovf_d = 1'b1;
          col_d = (eff_col == COL_MAX) ? eff_col : eff_col + 1'b1;
        end
      end else if (href_fall) begin
        // An unpaired trailing byte is simply forgotten here.
        phase_d = 1'b0;
        if (col_q != '0 && line_q != LINE_MAX) line_d = line_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      line_q       <= '0;
      px_data_q    <= '0;
      px_wr_q      <= 1'b0;
      px_addr_q    <= '0;
      frame_done_q <= 1'b0;
      px_ovf_q     <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      col_q        <= col_d;
      line_q       <= line_d;
      px_data_q    <= px_data_d;
      px_wr_q      <= px_wr_d;
      px_addr_q    <= px_addr_d;
      frame_done_q <= frame_done_d;
      px_ovf_q     <= px_ovf_d;
    end
  end

  assign px_data    = px_data_q;
  assign px_wr      = px_wr_q;
  assign px_addr    = px_addr_q;
  assign frame_done = frame_done_q;
  assign px_ovf     = px_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_pixel_capture.sv
// ---------------------------------------------------------------------------
// tb_cam_pixel_capture: directed vector bench for cam_pixel_capture
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cam_pixel_capture;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  d = 8'h00;
  logic [7:0]  px_data;
  logic        px_wr;
  logic [14:0] px_addr;
  logic        frame_done;
  logic        busy;
  logic        px_ovf;

  cam_pixel_capture #(.H_PIX(160), .V_LINES(120), .ADDR_W(15)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .en         (en),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .px_data    (px_data),
    .px_wr      (px_wr),
    .px_addr    (px_addr),
    .frame_done (frame_done),
    .busy       (busy),
    .px_ovf     (px_ovf)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        en;
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        wr;
    logic [7:0]  data;
    logic [14:0] addr;
    logic        busy;
    logic        fd;
    logic        ovf;
  } vec_t;

  vec_t tbl [20];

  int checks = 0;
  int failures = 0;

  int wr_cnt, fd_cnt, bad_data, b2b, last_addr, max_addr;
  logic prev_wr = 1'b0;
  logic [7:0] exp_px = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock edge, then sample #1 later and update the running frame statistics.
  task automatic step();
    @(posedge pclk);
    #1;
    if (px_wr) begin
      wr_cnt++;
      last_addr = int'(px_addr);
      if (int'(px_addr) > max_addr) max_addr = int'(px_addr);
      if (px_data != exp_px) bad_data++;
      if (prev_wr) b2b++;
    end
    prev_wr = px_wr;
    if (frame_done) fd_cnt++;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; fd_cnt = 0; bad_data = 0; b2b = 0; last_addr = -1; max_addr = -1;
  endtask

  task automatic run_line(input int npix, input logic [7:0] b0, input logic [7:0] b1);
    href = 1'b1;
    for (int p = 0; p < npix; p++) begin
      d = b0; step();
      d = b1; step();
    end
    href = 1'b0; d = 8'h00;
    step();
  endtask

  // Starts in WAIT_SOF with vsync high; ends back in WAIT_SOF with vsync high.
  task automatic run_frame(input int nlines, input int npix, input logic [7:0] b0, input logic [7:0] b1);
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    for (int l = 0; l < nlines; l++) run_line(npix, b0, b1);
    vsync = 1'b1; step();
    step();
  endtask

  initial begin
    //               en vs hr d      wr data   addr busy fd ovf
    tbl[0]  = '{1'b0,1'b1,1'b0,8'h00, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1,8'hF8, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,8'h1F, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1,8'hF8, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,8'h1F, 1'b0,8'h00,15'd0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,15'd0,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,8'hF8, 1'b0,8'h00,15'd0,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b1,8'h1F, 1'b1,8'hE3,15'd0,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,8'hE3,15'd1,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,8'hFF, 1'b0,8'hE3,15'd1,1'b1,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b1,8'hFF, 1'b1,8'hFF,15'd1,1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b1,8'hAA, 1'b0,8'hFF,15'd2,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,8'hFF,15'd2,1'b1,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1,8'h07, 1'b0,8'hFF,15'd2,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b1,8'hE0, 1'b1,8'h1C,15'd2,1'b1,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,8'h1C,15'd3,1'b1,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b1,1'b0,8'h00, 1'b0,8'h1C,15'd3,1'b0,1'b1,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b0,8'h00, 1'b0,8'h1C,15'd3,1'b0,1'b0,1'b0};

    clear_stats();

    // Reset state
    #12;
    chk("rst.px_wr", int'(px_wr), 0);
    chk("rst.px_data", int'(px_data), 0);
    chk("rst.px_addr", int'(px_addr), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.frame_done", int'(frame_done), 0);
    chk("rst.px_ovf", int'(px_ovf), 0);
    @(posedge pclk); #1;
    rst = 1'b1;

    // Idle gating, single pixel, orphan byte, frame end
    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en; vsync = tbl[i].vs; href = tbl[i].hr; d = tbl[i].d;
      step();
      chk($sformatf("v%0d.px_wr", i), int'(px_wr), int'(tbl[i].wr));
      chk($sformatf("v%0d.px_data", i), int'(px_data), int'(tbl[i].data));
      chk($sformatf("v%0d.px_addr", i), int'(px_addr), int'(tbl[i].addr));
      chk($sformatf("v%0d.busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("v%0d.frame_done", i), int'(frame_done), int'(tbl[i].fd));
      chk($sformatf("v%0d.px_ovf", i), int'(px_ovf), int'(tbl[i].ovf));
    end
    en = 1'b0;

    // Full frame of green pixels
    clear_stats();
    exp_px = 8'h1C;
    run_frame(120, 160, 8'h07, 8'hE0);
    chk("full.wr_count", wr_cnt, 19200);
    chk("full.last_addr", last_addr, 19199);
    chk("full.bad_data", bad_data, 0);
    chk("full.frame_done_count", fd_cnt, 1);
    chk("full.back_to_back", b2b, 0);
    chk("full.px_ovf", int'(px_ovf), 0);

    // Oversized frame: 121 lines of 162 pixels
    clear_stats();
    exp_px = 8'hE3;
    run_frame(121, 162, 8'hF8, 8'h1F);
    chk("ovf.wr_count", wr_cnt, 19200);
    chk("ovf.max_addr", max_addr, 19199);
    chk("ovf.bad_data", bad_data, 0);
    chk("ovf.frame_done_count", fd_cnt, 1);
    chk("ovf.px_ovf_sticky", int'(px_ovf), 1);
    vsync = 1'b0; step();
    chk("ovf.px_ovf_cleared", int'(px_ovf), 0);
    chk("ovf.busy", int'(busy), 1);

    // Reset in the middle of a frame, right as pixel 500 is being written
    clear_stats();
    exp_px = 8'h1C;
    for (int l = 0; l < 3; l++) run_line(160, 8'h07, 8'hE0);
    href = 1'b1;
    for (int p = 0; p < 20; p++) begin
      d = 8'h07; step();
      d = 8'hE0; step();
    end
    chk("mid.px_wr_before", int'(px_wr), 1);
    chk("mid.px_addr_before", int'(px_addr), 499);
    #2;
    rst = 1'b0;
    #1;
    chk("mid.px_wr", int'(px_wr), 0);
    chk("mid.px_addr", int'(px_addr), 0);
    chk("mid.px_data", int'(px_data), 0);
    chk("mid.busy", int'(busy), 0);
    chk("mid.px_ovf", int'(px_ovf), 0);
    href = 1'b0; d = 8'h00; vsync = 1'b0;
    step();
    rst = 1'b1;
    en = 1'b1; step();
    en = 1'b0;
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    chk("mid.busy_again", int'(busy), 1);
    href = 1'b1;
    d = 8'hF8; step();
    d = 8'h1F; step();
    chk("mid.restart_wr", int'(px_wr), 1);
    chk("mid.restart_addr", int'(px_addr), 0);
    chk("mid.restart_data", int'(px_data), 8'hE3);
    href = 1'b0; d = 8'h00; step();
    chk("mid.restart_addr_next", int'(px_addr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
